res_seq_ctrl: RTL

Run sequencer for the ESN reservoir datapath. It replaces the free-running slow divider and address counter with a start/stop-controlled run of N input samples. It drives the input ROM address, issues one sample every STEP_CYCLES clocks, and clears the state feedback registers at run start. It also tracks samples through the PE pipeline, so downstream logic gets a `out_valid`/`out_addr` pair aligned with XSTATE, followed by a `done` pulse when the run has fully drained.

---
 rtl/res_seq_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/res_seq_ctrl.sv
// Start/stop run sequencer for the ESN reservoir: ROM addressing, sample issue, state clear and
// XSTATE-aligned valid tracking. Define RES_SEQ_WASHOUT_EN to suppress the first WASHOUT outputs.
module res_seq_ctrl #(
    parameter int ADDR_W      = 6,
    parameter int STEP_CYCLES = 4,
    parameter int PIPE_LAT    = 6,
    parameter int WASHOUT     = 8
) (
    input  logic              clk,
    input  logic              rst_N,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W:0]   num_samples,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              fb_clr,
    output logic              step,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam int PH_W = $clog2(STEP_CYCLES);
    localparam int DR_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ADDR_W:0]  MAX_N   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(STEP_CYCLES - 1);
    localparam logic [DR_W-1:0]  DR_LAST = DR_W'(PIPE_LAT - 1);
`ifdef RES_SEQ_WASHOUT_EN
    localparam logic WASH_EN = 1'b1;
`else
    localparam logic WASH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [DR_W-1:0]   drain_q, drain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;

    logic [ADDR_W:0]   num_clamped;
    logic              accept;
    logic              issue;
    logic              last_issue;

    logic [PIPE_LAT-1:0] pvld_q;
    logic [ADDR_W-1:0]   paddr_q [PIPE_LAT];
    logic                in_washout;

    always_comb begin
        num_clamped = (num_samples > MAX_N) ? MAX_N : num_samples;
        accept      = (state_q == S_IDLE) && start && (num_clamped != '0);
        // A stop in the last phase wins over the issue: the partial sample is dropped.
        issue       = (state_q == S_RUN) && !stop && (phase_q == PH_LAST);
        last_issue  = issue && ({1'b0, addr_q} == (num_q - 1'b1));
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CLEAR;
            S_CLEAR: state_d = S_RUN;
            S_RUN:   if (stop || last_issue) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == DR_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        num_d   = num_q;
        phase_d = phase_q;
        drain_d = drain_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) num_d = num_clamped;
            end
            S_CLEAR: begin
                phase_d = '0;
                addr_d  = '0;
            end
            S_RUN: begin
                drain_d = '0;
                if (!stop) begin
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        // The address holds at N-1 on the final issue so it never wraps.
                        if (!last_issue) addr_d = addr_q + 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DR_LAST) begin
                    drain_d = '0;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            num_q   <= '0;
            phase_q <= '0;
            drain_q <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            num_q   <= num_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        rom_addr = addr_q;
        fb_clr   = (state_q == S_CLEAR);
        busy     = (state_q != S_IDLE);
        step     = issue;
        done     = done_q;
    end

    // Tracking pipe mirrors the ROM + PE latency; it free-runs so in-flight samples survive DRAIN.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            pvld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) paddr_q[i] <= '0;
        end else begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                if (i == 0) begin
                    pvld_q[0]  <= issue;
                    paddr_q[0] <= addr_q;
                end else begin
                    pvld_q[i]  <= pvld_q[i-1];
                    paddr_q[i] <= paddr_q[i-1];
                end
            end
        end
    end

    always_comb begin
        in_washout = WASH_EN && ({{(32-ADDR_W){1'b0}}, paddr_q[PIPE_LAT-1]} < 32'(WASHOUT));
        out_valid  = pvld_q[PIPE_LAT-1] && !in_washout;
        out_addr   = paddr_q[PIPE_LAT-1];
    end

endmodule
